addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/alu_pkg.sv | 19 +
 rtl/addsub_core.sv | 58 +++++
 rtl/addsub_pipe.sv | 89 ++++++++
 tb/tb_addsub_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared operation encodings and status bit positions for the add/subtract pipeline.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBB = 2'd3
    } op_e;

    localparam int unsigned STATUS_W = 4;

    // status = {C, V, Z, N}
    localparam int unsigned ST_C = 3;
    localparam int unsigned ST_V = 2;
    localparam int unsigned ST_Z = 1;
    localparam int unsigned ST_N = 0;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract with carry/borrow-in, optional signed saturation and C/V/Z/N flags.
module addsub_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SAT   = 0
) (
    input  logic [WIDTH-1:0]    in1,
    input  logic [WIDTH-1:0]    in2,
    input  logic [1:0]          flag,
    input  logic                cin,
    output logic [WIDTH-1:0]    result,
    output logic [STATUS_W-1:0] status
);

    op_e              op;
    logic             is_sub;
    logic             use_c;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;
    logic             carry;
    logic             ovf;

    assign op = op_e'(flag);

    always_comb begin
        is_sub = (op == OP_SUB) || (op == OP_SBB);
        use_c  = ((op == OP_ADC) || (op == OP_SBB)) && cin;

        // Bit WIDTH is the carry-out for additions and the borrow for subtractions.
        if (is_sub) begin
            sum = {1'b0, in1} - {1'b0, in2} - {{WIDTH{1'b0}}, use_c};
        end else begin
            sum = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, use_c};
        end
        raw   = sum[WIDTH-1:0];
        carry = sum[WIDTH];

        if (is_sub) begin
            ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (raw[WIDTH-1] != in1[WIDTH-1]);
        end else begin
            ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (raw[WIDTH-1] != in1[WIDTH-1]);
        end

        // On overflow the sign of in1 tells which way the true result escaped.
        result = raw;
        if ((SAT != 0) && ovf) begin
            result = in1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end

        status       = '0;
        status[ST_C] = carry;
        status[ST_V] = ovf;
        status[ST_Z] = (result == '0);
        status[ST_N] = result[WIDTH-1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage valid/ready add/subtract pipeline: S1 holds operands, S2 holds result and status.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SAT   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in1,
    input  logic [WIDTH-1:0]    in2,
    input  logic [1:0]          flag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out,
    output logic [STATUS_W-1:0] status
);

    logic                s1_valid_q;
    logic [WIDTH-1:0]    s1_in1_q;
    logic [WIDTH-1:0]    s1_in2_q;
    logic [1:0]          s1_flag_q;
    logic                s2_valid_q;
    logic [WIDTH-1:0]    s2_out_q;
    logic [STATUS_W-1:0] s2_status_q;
    logic                carry_q;

    logic                s2_free;
    logic                advance;
    logic                accept;
    logic [WIDTH-1:0]    core_result;
    logic [STATUS_W-1:0] core_status;

    assign s2_free  = !s2_valid_q || out_ready;
    assign advance  = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;

    // Beats advance in order, so carry_q always holds the previous beat's C at advance time.
    addsub_core #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_core (
        .in1    (s1_in1_q),
        .in2    (s1_in2_q),
        .flag   (s1_flag_q),
        .cin    (carry_q),
        .result (core_result),
        .status (core_status)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_in1_q    <= '0;
            s1_in2_q    <= '0;
            s1_flag_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_out_q    <= '0;
            s2_status_q <= '0;
            carry_q     <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_in1_q   <= in1;
                s1_in2_q   <= in2;
                s1_flag_q  <= flag;
            end else if (advance) begin
                s1_valid_q <= 1'b0;
            end

            if (advance) begin
                s2_valid_q  <= 1'b1;
                s2_out_q    <= core_result;
                s2_status_q <= core_status;
                carry_q     <= core_status[ST_C];
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = s2_out_q;
    assign status    = s2_status_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: wrap and saturating instances share stimulus; scoreboard checks results.
module tb_addsub_pipe;

    localparam int unsigned W = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [1:0]   flag = '0;
    logic         in_ready, out_valid, in_ready_s, out_valid_s;
    logic [W-1:0] out, out_s;
    logic [3:0]   status, status_s;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .SAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .flag(flag), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .status(status)
    );

    addsub_pipe #(.WIDTH(W), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in1(in1), .in2(in2), .flag(flag), .out_valid(out_valid_s),
        .out_ready(out_ready), .out(out_s), .status(status_s)
    );

    typedef struct {
        logic [1:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] eo;
        logic [3:0]  es;
        logic [63:0] eos;
        logic [3:0]  ess;
    } vec_t;

    typedef struct {
        logic [63:0] o0;
        logic [3:0]  s0;
        logic [63:0] o1;
        logic [3:0]  s1;
    } exp_t;

    exp_t sbq[$];
    vec_t tab[13];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   cyc = 0;
    logic mdl_c = 1'b0;
    logic drv_done = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: exact signed/unsigned arithmetic in wider words, independent of bit tricks.
    task automatic model(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, output exp_t e, output logic cout);
        logic signed [65:0] sa, sb, ci, tv, hi, lo;
        logic [65:0] ua, ub, uc;
        logic v;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        ci = {65'd0, f[1] & cin};
        ua = {2'b00, a};
        ub = {2'b00, b};
        uc = {65'd0, f[1] & cin};
        hi = 66'sh0_7FFF_FFFF_FFFF_FFFF;
        lo = -hi - 66'sd1;
        if (f[0]) begin
            tv   = sa - sb - ci;
            cout = (ua < ub + uc);
        end else begin
            tv   = sa + sb + ci;
            cout = ((ua + ub + uc) >= 66'h1_0000_0000_0000_0000);
        end
        v    = (tv > hi) || (tv < lo);
        e.o0 = tv[63:0];
        e.s0 = {cout, v, e.o0 == 64'd0, e.o0[63]};
        e.o1 = !v ? e.o0 : ((tv < 66'sd0) ? MINN : MAXP);
        e.s1 = {cout, v, e.o1 == 64'd0, e.o1[63]};
    endtask

    task automatic drive(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        in_valid = 1'b1;
        flag     = f;
        in1      = a;
        in2      = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low expected=accepted");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic c;
        model(f, a, b, mdl_c, e, c);
        mdl_c = c;
        drive(f, a, b);
        sbq.push_back(e);
    endtask

    task automatic send_vec(input vec_t t);
        exp_t e;
        logic c;
        model(t.f, t.a, t.b, mdl_c, e, c);
        mdl_c = c;
        drive(t.f, t.a, t.b);
        e.o0 = t.eo;
        e.s0 = t.es;
        e.o1 = t.eos;
        e.s1 = t.ess;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 72'(sbq.size()), 72'd0);
        sbq.delete();
        @(negedge clk);
        check("idle_after_drain", {71'd0, out_valid}, 72'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MAXP;
            3:       return MINN;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pop on every output handshake, and verify hold while stalled.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_out;
    logic [3:0]  prev_st;
    exp_t        mon_e;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {3'd0, out_valid, status, out}, {3'd0, 1'b1, prev_st, prev_out});
            end
            if (out_valid && out_ready) begin
                pops++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h expected=no_beat", out);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", {4'd0, status, out}, {4'd0, mon_e.s0, mon_e.o0});
                    check("result_sat", {3'd0, out_valid_s, status_s, out_s},
                          {3'd0, 1'b1, mon_e.s1, mon_e.o1});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            prev_st    = status;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        int   p0;
        logic [1:0] rf;

        tab[0]  = '{2'd0, 64'd10, 64'd5, 64'd15, 4'b0000, 64'd15, 4'b0000};
        tab[1]  = '{2'd1, 64'd20, 64'd7, 64'd13, 4'b0000, 64'd13, 4'b0000};
        tab[2]  = '{2'd1, 64'd100, 64'd200, 64'hFFFF_FFFF_FFFF_FF9C, 4'b1001,
                    64'hFFFF_FFFF_FFFF_FF9C, 4'b1001};
        tab[3]  = '{2'd3, 64'd0, 64'd0, ONES, 4'b1001, ONES, 4'b1001};
        tab[4]  = '{2'd0, ONES, 64'd1, 64'd0, 4'b1010, 64'd0, 4'b1010};
        tab[5]  = '{2'd2, 64'd0, 64'd0, 64'd1, 4'b0000, 64'd1, 4'b0000};
        tab[6]  = '{2'd0, MAXP, 64'd1, MINN, 4'b0101, MAXP, 4'b0100};
        tab[7]  = '{2'd1, MINN, 64'd1, MAXP, 4'b0100, MINN, 4'b0101};
        tab[8]  = '{2'd0, MINN, MINN, 64'd0, 4'b1110, MINN, 4'b1101};
        tab[9]  = '{2'd2, 64'd5, 64'd6, 64'd12, 4'b0000, 64'd12, 4'b0000};
        tab[10] = '{2'd3, 64'd5, 64'd6, ONES, 4'b1001, ONES, 4'b1001};
        tab[11] = '{2'd2, 64'h7FFF_FFFF_FFFF_FFFE, 64'd0, MAXP, 4'b0000, MAXP, 4'b0000};
        tab[12] = '{2'd3, 64'd0, 64'd0, 64'd0, 4'b0010, 64'd0, 4'b0010};

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", {71'd0, in_ready}, 72'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out", {3'd0, out_valid, status, out}, 72'd0);
        check("reset_in_ready", {70'd0, in_ready, in_ready_s}, 72'd3);
        @(posedge clk);
        #1;

        // Latency: present in cycle 0, valid in cycle 2
        begin
            exp_t e;
            logic c;
            model(2'd0, 64'd1, 64'd2, mdl_c, e, c);
            mdl_c = c;
            sbq.push_back(e);
            in_valid = 1'b1;
            flag = 2'd0;
            in1 = 64'd1;
            in2 = 64'd2;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("latency_cycle1", {71'd0, out_valid}, 72'd0);
            @(negedge clk);
            check("latency_cycle2", {71'd0, out_valid}, 72'd1);
        end
        drain();

        // Table vectors back-to-back, one accept per cycle
        c0 = cyc;
        for (int i = 0; i < 13; i++) send_vec(tab[i]);
        check("throughput_cycles", 72'(cyc - c0), 72'd13);
        drain();

        // Stall: out_ready low, two accepts then in_ready drops
        p0 = pops;
        out_ready = 1'b0;
        send(2'd0, ONES, ONES);
        send(2'd2, 64'd1, 64'd2);
        @(negedge clk);
        check("stall_in_ready", {71'd0, in_ready}, 72'd0);
        check("stall_inflight", 72'(sbq.size()), 72'd2);
        fork
            send(2'd3, 64'd3, 64'd5);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(2'd2, 64'd10, 64'd0);
        drain();
        check("stall_beat_count", 72'(pops - p0), 72'd4);

        // Reset mid-operation discards beats and carry
        out_ready = 1'b0;
        send(2'd0, MINN, MINN);
        send(2'd0, 64'd1, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        mdl_c = 1'b0;
        @(negedge clk);
        check("midreset_out", {3'd0, out_valid, status, out}, 72'd0);
        check("midreset_in_ready", {71'd0, in_ready}, 72'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_vec('{2'd2, 64'd1, 64'd1, 64'd2, 4'b0000, 64'd2, 4'b0000});
        drain();

        // Random beats with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rf = 2'($urandom_range(0, 3));
                    send(rf, pick(), pick());
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
